// File: rtl/match_event_logger_if.sv
// Timestamp drain channel: valid/ready handshake carrying the FIFO head.
// The logger is the master; the consumer returns ts_ready.
interface match_event_logger_if #(
    parameter int TS_W = 8
);
    logic [TS_W-1:0] ts_out;
    logic            ts_valid;
    logic            ts_ready;

    modport master (
        output ts_out,
        output ts_valid,
        input  ts_ready
    );

    modport slave (
        input  ts_out,
        input  ts_valid,
        output ts_ready
    );
endinterface

// File: rtl/match_event_logger.sv
// Timestamps detector match pulses into a first-word-fall-through FIFO, drained
// over a valid/ready channel; also keeps a saturating match count and a sticky overflow.
module match_event_logger #(
    parameter  int TS_W  = 8,
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   match_in,
    input  logic                   clear,
    match_event_logger_if.master   ts_if,
    output logic [LVL_W-1:0]       fifo_level,
    output logic [CNT_W-1:0]       match_count,
    output logic                   overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  mem_q [DEPTH];

    logic empty, full, pop, push;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    // A full FIFO still accepts a match when the head leaves in the same cycle.
    assign pop   = !empty && ts_if.ts_ready && !clear;
    assign push  = match_in && !clear && (!full || pop);

    // NOTE: every next-state value is defaulted first so no path leaves one unassigned and infers a latch.
    always_comb begin
        ts_d     = ts_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            ts_d = ts_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;
            if (match_in && !push) ovf_d = 1'b1;
            if (match_in && (count_q != '1)) count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is not reset; an entry is only visible once level_q counts it, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ts_q;
    end

    assign ts_if.ts_valid = !empty;
    assign ts_if.ts_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level     = level_q;
    assign match_count    = count_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger; a local cycle counter tracks the
// DUT timestamp so matches can be placed at chosen ts values.
module tb_match_event_logger;
    localparam int TS_W  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             match_in;
    logic             clear;
    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] match_count;
    logic             overflow;

    match_event_logger_if #(.TS_W(TS_W)) ts_if ();

    match_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .match_in   (match_in),
        .clear      (clear),
        .ts_if      (ts_if.master),
        .fifo_level (fifo_level),
        .match_count(match_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ts_m    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        ts_m = (ts_m + 1) % 256;
    endtask

    task automatic wait_ts(input int t);
        while (ts_m != t) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        ts_m  = 0;
    endtask

    initial begin
        int exp_q[4];
        rstn = 1'b0; match_in = 1'b0; clear = 1'b0; ts_if.ts_ready = 1'b0;

        // 1. reset and idle
        repeat (3) step();
        rstn = 1'b1;
        ts_m = 0;
        repeat (10) step();
        check("idle_valid", 32'(ts_if.ts_valid), 0);
        check("idle_ts_out", 32'(ts_if.ts_out), 0);
        check("idle_level", 32'(fifo_level), 0);
        check("idle_count", 32'(match_count), 0);
        check("idle_ovf", 32'(overflow), 0);

        // asynchronous reset mid-cycle with one entry buffered
        match_in = 1'b1;
        step();
        match_in = 1'b0;
        check("pre_rst_valid", 32'(ts_if.ts_valid), 1);
        check("pre_rst_ts_out", 32'(ts_if.ts_out), 10);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_valid", 32'(ts_if.ts_valid), 0);
        check("async_rst_ts_out", 32'(ts_if.ts_out), 0);
        check("async_rst_level", 32'(fifo_level), 0);
        check("async_rst_count", 32'(match_count), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ts_m = 0;

        // 2. single match at ts=5
        ts_if.ts_ready = 1'b1;
        wait_ts(5);
        match_in = 1'b1;
        step();
        match_in = 1'b0;
        check("single_valid", 32'(ts_if.ts_valid), 1);
        check("single_ts_out", 32'(ts_if.ts_out), 5);
        check("single_level", 32'(fifo_level), 1);
        check("single_count", 32'(match_count), 1);
        step();
        check("single_drained_valid", 32'(ts_if.ts_valid), 0);
        check("single_drained_level", 32'(fifo_level), 0);

        // 3. fill and overflow at ts=10..14
        do_clear();
        ts_if.ts_ready = 1'b0;
        wait_ts(10);
        match_in = 1'b1;
        repeat (5) step();
        match_in = 1'b0;
        check("fill_level", 32'(fifo_level), 4);
        check("fill_ovf", 32'(overflow), 1);
        check("fill_count", 32'(match_count), 5);
        check("fill_head", 32'(ts_if.ts_out), 10);
        step();
        check("stall_head_stable", 32'(ts_if.ts_out), 10);
        ts_if.ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), 32'(ts_if.ts_out), 32'(10 + i));
            step();
        end
        check("drain_empty_valid", 32'(ts_if.ts_valid), 0);
        check("drain_ovf_sticky", 32'(overflow), 1);

        // 4. full FIFO with concurrent push and pop at ts=30
        do_clear();
        ts_if.ts_ready = 1'b0;
        wait_ts(20);
        match_in = 1'b1;
        repeat (4) step();
        match_in = 1'b0;
        wait_ts(30);
        check("full_level", 32'(fifo_level), 4);
        match_in = 1'b1;
        ts_if.ts_ready = 1'b1;
        step();
        match_in = 1'b0;
        ts_if.ts_ready = 1'b0;
        check("pushpop_level", 32'(fifo_level), 4);
        check("pushpop_ovf", 32'(overflow), 0);
        exp_q = '{21, 22, 23, 30};
        ts_if.ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pushpop_drain_%0d", i), 32'(ts_if.ts_out), 32'(exp_q[i]));
            step();
        end
        check("pushpop_empty", 32'(ts_if.ts_valid), 0);

        // 5. timestamp wrap, then match-count saturation
        do_clear();
        ts_if.ts_ready = 1'b1;
        wait_ts(255);
        match_in = 1'b1;
        step();
        check("wrap_first", 32'(ts_if.ts_out), 255);
        step();
        match_in = 1'b0;
        check("wrap_second", 32'(ts_if.ts_out), 0);
        check("wrap_level", 32'(fifo_level), 1);
        step();
        check("wrap_empty", 32'(ts_if.ts_valid), 0);
        match_in = 1'b1;
        repeat (300) step();
        match_in = 1'b0;
        check("sat_count", 32'(match_count), 255);
        check("sat_no_ovf", 32'(overflow), 0);

        // 6. clear beats match and ready
        do_clear();
        ts_if.ts_ready = 1'b0;
        match_in = 1'b1;
        repeat (5) step();
        match_in = 1'b0;
        ts_if.ts_ready = 1'b1;
        repeat (2) step();
        check("pre_clear_level", 32'(fifo_level), 2);
        check("pre_clear_ovf", 32'(overflow), 1);
        match_in = 1'b1;
        do_clear();
        match_in = 1'b0;
        check("clear_level", 32'(fifo_level), 0);
        check("clear_valid", 32'(ts_if.ts_valid), 0);
        check("clear_count", 32'(match_count), 0);
        check("clear_ovf", 32'(overflow), 0);
        ts_if.ts_ready = 1'b0;
        match_in = 1'b1;
        step();
        match_in = 1'b0;
        check("post_clear_ts", 32'(ts_if.ts_out), 0);
        check("post_clear_valid", 32'(ts_if.ts_valid), 1);
        check("post_clear_count", 32'(match_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
